masked_rand_source: RTL and testbench
=====================================

// Module: masked_rand_source
// PURPOSE
// - Upstream randomness stage for HPC3 masked multipliers: supplies fresh r/p mask bits every consumed cycle.
// - 128-bit LFSR, seeded over a 32-bit word handshake, unrolled RAND_BITS steps per advance.
// - Output layout drives NUM_MULS masked_hpc3_1_mul instances directly (one r and one p bus per multiplier).
// PARAMETERS
// - NUM_SHARES     3  share count of the fed multipliers; NQ = num_quad(NUM_SHARES)
// - BIT_WIDTH      1  bits per share element
// - NUM_MULS       2  multipliers fed in parallel
// - WARMUP_CYCLES  4  LFSR advances discarded after seeding (0 allowed)
// - derived RAND_BITS = 2*NUM_MULS*NQ*BIT_WIDTH; elaboration error if RAND_BITS > 128
// PORTS
// - in_clock        in   1                         single clock, rising edge
// - in_reset        in   1                         asynchronous, active-low reset
// - in_seed         in   32                        seed word, most significant word first
// - in_seed_valid   in   1                         seed word offered
// - out_seed_ready  out  1                         seed word accepted when valid&&ready
// - in_reseed       in   1                         request new seed (honoured in RUN only)
// - out_r           out  T[NUM_MULS][NQ]           r masks, mul m -> out_r[m]
// - out_p           out  T[NUM_MULS][NQ]           p masks, mul m -> out_p[m]
// - out_valid       out  1                         masks are fresh and consumable
// - in_ready        in   1                         consumer takes current masks this cycle
// - out_seed_error  out  1                         one-cycle pulse: all-zero seed rejected
// BEHAVIOUR
// - Reset (in_reset=0, async): state=128'h0, FSM=SEED, word counter=0, warm counter=0;
//   out_seed_ready=0 during reset, out_valid=0, out_seed_error=0, out_r/out_p=0.
// - FSM states SEED -> CHECK -> WARM -> RUN:
//   SEED: out_seed_ready=1; per handshake state<={state[95:0],in_seed}, cnt++; after 4th word -> CHECK.
//   CHECK (1 cycle): state==0 -> out_seed_error=1, cnt=0, -> SEED; else -> WARM (or RUN if WARMUP_CYCLES=0).
//   WARM: advance LFSR once per cycle for WARMUP_CYCLES cycles, then -> RUN.
//   RUN: out_valid=1; advance LFSR only on out_valid&&in_ready; hold masks while in_ready=0.
// - LFSR bit step (x^128+x^29+x^27+x^2+1): fb=s[127]^s[28]^s[26]^s[1]; s<={s[126:0],fb}.
//   One advance = RAND_BITS consecutive bit steps, computed combinationally in one cycle.
// - Mapping: out_r[m][q]=state[(m*NQ+q)*BW +: BW]; out_p[m][q]=state[(NUM_MULS*NQ+m*NQ+q)*BW +: BW].
// - out_r/out_p forced to 0 whenever out_valid=0 (seed never exposed before RUN).
// - in_reseed in RUN: next cycle FSM=SEED, out_valid=0, cnt=0; a coincident in_ready handshake
//   completes (masks consumed) but the advance is irrelevant; state is overwritten by the new seed.
// - in_reseed outside RUN ignored; in_seed_valid outside SEED ignored.
// - Latency reset release -> first out_valid: 4 seed handshakes + 1 CHECK + WARMUP_CYCLES cycles.
// - Reset asserted mid-operation: immediate return to reset values, any partial seed discarded.
// - Nonzero state never becomes zero (maximal-length LFSR); no runtime check beyond CHECK.
// STRUCTURE
// - aes128_package: add LFSR_WIDTH=128, SEED_WORD_WIDTH=32, SEED_WORDS=4, tap localparams,
//   rand_bits(NUM_SHARES,BIT_WIDTH,NUM_MULS) function; reuse existing num_quad.
// - Sub-module masked_rand_lfsr_step #(STEPS): combinational 128-bit state -> state advanced STEPS bits.
// - Top: FSM, seed/warm counters, state register, output slicing and zero-gating.
// TESTING
// - Reset, then 4 words 0,0,0,0 -> out_seed_error pulse 1 cycle after CHECK, back to SEED, out_valid stays 0.
// - WARMUP_CYCLES=0, words 0,0,0,32'h0000_0ABC -> out_valid next after CHECK, {p,r} low 12 bits = 12'hABC.
// - In RUN hold in_ready=0 for 5 cycles -> out_r/out_p stable; raise in_ready -> new masks every cycle
//   matching a bit-serial golden model of the polynomial (1000 advances, defaults).
// - in_reseed with in_ready=1 in RUN -> out_valid=0 next cycle, out_seed_ready=1, outputs 0.
// - Drop in_reset after 2 of 4 seed words -> all outputs 0 immediately; restart needs 4 full words.
// - Seed handshake with gaps (in_seed_valid toggling) -> only valid&&ready words shifted in.

Source files
------------

// File: rtl/masked_rand_source_pkg.sv
// -----------------------------------------------------------------------------
// masked_rand_source_pkg
// Shared constants, FSM state type and helper functions for the masked
// randomness source:
//   - LFSR geometry (128-bit state, 32-bit seed words, 4 words per seed)
//   - feedback tap positions of x^128 + x^29 + x^27 + x^2 + 1
//   - num_quad / rand_bits sizing helpers for the fed HPC3 multipliers
//   - lfsr_bit_step: one serial step of the LFSR
// -----------------------------------------------------------------------------
package masked_rand_source_pkg;

    localparam int unsigned LFSR_WIDTH      = 128;
    localparam int unsigned SEED_WORD_WIDTH = 32;
    localparam int unsigned SEED_WORDS      = 4;
    localparam int unsigned SEED_CNT_WIDTH  = $clog2(SEED_WORDS);

    // Feedback taps, indexed into the state vector (bit 0 receives feedback).
    localparam int unsigned LFSR_TAP_A = 127;
    localparam int unsigned LFSR_TAP_B = 28;
    localparam int unsigned LFSR_TAP_C = 26;
    localparam int unsigned LFSR_TAP_D = 1;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_CHECK,
        ST_WARM,
        ST_RUN
    } rand_src_state_e;

    // Number of share pairs (i<j) of an n-share masking.
    function automatic int unsigned num_quad(input int unsigned num_shares);
        return (num_shares * (num_shares - 1)) / 2;
    endfunction

    // Fresh bits needed per consumed cycle: one r and one p bus per multiplier.
    function automatic int unsigned rand_bits(input int unsigned num_shares,
                                              input int unsigned bit_width,
                                              input int unsigned num_muls);
        return 2 * num_muls * num_quad(num_shares) * bit_width;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_bit_step(input logic [LFSR_WIDTH-1:0] s);
        logic fb;
        fb = s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D];
        return {s[LFSR_WIDTH-2:0], fb};
    endfunction

endpackage

// File: rtl/masked_rand_source_if.sv
// -----------------------------------------------------------------------------
// masked_rand_source_if
// Seed handshake and mask delivery bundle of masked_rand_source.
//   in_seed / in_seed_valid / out_seed_ready : 32-bit seed words, MS word first
//   in_reseed                                : request a new seed while running
//   out_r / out_p                            : [NUM_MULS][NQ] masks of BIT_WIDTH
//   out_valid / in_ready                     : mask handshake
//   out_seed_error                           : one-cycle pulse, all-zero seed
// master : the randomness source, slave : seed provider / mask consumer.
// -----------------------------------------------------------------------------
interface masked_rand_source_if #(
    parameter int unsigned NUM_MULS  = 2,
    parameter int unsigned NQ        = 3,
    parameter int unsigned BIT_WIDTH = 1
);
    logic [31:0]                                 in_seed;
    logic                                        in_seed_valid;
    logic                                        out_seed_ready;
    logic                                        in_reseed;
    logic [NUM_MULS-1:0][NQ-1:0][BIT_WIDTH-1:0]  out_r;
    logic [NUM_MULS-1:0][NQ-1:0][BIT_WIDTH-1:0]  out_p;
    logic                                        out_valid;
    logic                                        in_ready;
    logic                                        out_seed_error;

    modport master (
        input  in_seed,
        input  in_seed_valid,
        output out_seed_ready,
        input  in_reseed,
        output out_r,
        output out_p,
        output out_valid,
        input  in_ready,
        output out_seed_error
    );

    modport slave (
        output in_seed,
        output in_seed_valid,
        input  out_seed_ready,
        output in_reseed,
        input  out_r,
        input  out_p,
        input  out_valid,
        output in_ready,
        input  out_seed_error
    );
endinterface

// File: rtl/masked_rand_lfsr_step.sv
// -----------------------------------------------------------------------------
// masked_rand_lfsr_step
// Purely combinational: advances the 128-bit LFSR state by STEPS serial steps
// in a single cycle.
//   in_state  : current state
//   out_state : state after STEPS bit steps
// -----------------------------------------------------------------------------
module masked_rand_lfsr_step
    import masked_rand_source_pkg::*;
#(
    parameter int unsigned STEPS = 12
) (
    input  logic [LFSR_WIDTH-1:0] in_state,
    output logic [LFSR_WIDTH-1:0] out_state
);

    always_comb begin
        out_state = in_state;
        for (int unsigned i = 0; i < STEPS; i++) begin
            out_state = lfsr_bit_step(out_state);
        end
    end

endmodule

// File: rtl/masked_rand_source.sv
// -----------------------------------------------------------------------------
// masked_rand_source
// Fresh r/p mask source for NUM_MULS HPC3 masked multipliers. A 128-bit LFSR
// is seeded with four 32-bit words, checked for the forbidden all-zero state,
// warmed up for WARMUP_CYCLES advances and then advanced RAND_BITS bit steps
// every time the consumer takes the masks.
//   in_clock : rising-edge clock
//   in_reset : asynchronous, active-low reset
//   bus      : seed handshake, reseed request, masks and mask handshake
//              (see masked_rand_source_if)
// -----------------------------------------------------------------------------
module masked_rand_source
    import masked_rand_source_pkg::*;
#(
    parameter int unsigned NUM_SHARES    = 3,
    parameter int unsigned BIT_WIDTH     = 1,
    parameter int unsigned NUM_MULS      = 2,
    parameter int unsigned WARMUP_CYCLES = 4
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    masked_rand_source_if.master bus
);

    localparam int unsigned NQ        = num_quad(NUM_SHARES);
    localparam int unsigned RAND_BITS = rand_bits(NUM_SHARES, BIT_WIDTH, NUM_MULS);
    localparam int unsigned MASK_BITS = NUM_MULS * NQ * BIT_WIDTH;

    localparam int unsigned WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST =
        WARM_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
    localparam logic [SEED_CNT_WIDTH-1:0] WORD_LAST = SEED_CNT_WIDTH'(SEED_WORDS - 1);

    generate
        if (RAND_BITS > LFSR_WIDTH) begin : g_bad_cfg
            $error("masked_rand_source: RAND_BITS (%0d) exceeds LFSR width (%0d)",
                   RAND_BITS, LFSR_WIDTH);
        end
    endgenerate

    rand_src_state_e             fsm;
    logic [LFSR_WIDTH-1:0]       lfsr;
    logic [LFSR_WIDTH-1:0]       lfsr_next;
    logic [SEED_CNT_WIDTH-1:0]   word_cnt;
    logic [WARM_W-1:0]           warm_cnt;
    logic                        seed_ready_q;
    logic                        valid_q;
    logic                        error_q;

    masked_rand_lfsr_step #(
        .STEPS (RAND_BITS)
    ) u_step (
        .in_state  (lfsr),
        .out_state (lfsr_next)
    );

    // seed_ready_q is registered so it stays low while reset is asserted and
    // rises on the first clock after release; it doubles as the SEED-state
    // acceptance qualifier.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            fsm          <= ST_SEED;
            lfsr         <= '0;
            word_cnt     <= '0;
            warm_cnt     <= '0;
            seed_ready_q <= 1'b0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (fsm)
                ST_SEED: begin
                    if (bus.in_seed_valid && seed_ready_q) begin
                        lfsr <= {lfsr[LFSR_WIDTH-SEED_WORD_WIDTH-1:0], bus.in_seed};
                        if (word_cnt == WORD_LAST) begin
                            word_cnt     <= '0;
                            seed_ready_q <= 1'b0;
                            fsm          <= ST_CHECK;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        seed_ready_q <= 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (lfsr == '0) begin
                        error_q      <= 1'b1;
                        word_cnt     <= '0;
                        seed_ready_q <= 1'b1;
                        fsm          <= ST_SEED;
                    end else if (WARMUP_CYCLES == 0) begin
                        valid_q <= 1'b1;
                        fsm     <= ST_RUN;
                    end else begin
                        warm_cnt <= '0;
                        fsm      <= ST_WARM;
                    end
                end

                ST_WARM: begin
                    lfsr <= lfsr_next;
                    if (warm_cnt == WARM_LAST) begin
                        valid_q <= 1'b1;
                        fsm     <= ST_RUN;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    // A reseed wins over a coincident consume: the masks are
                    // taken, but the state is about to be overwritten anyway.
                    if (bus.in_reseed) begin
                        valid_q      <= 1'b0;
                        word_cnt     <= '0;
                        seed_ready_q <= 1'b1;
                        fsm          <= ST_SEED;
                    end else if (bus.in_ready) begin
                        lfsr <= lfsr_next;
                    end
                end

                default: begin
                    valid_q      <= 1'b0;
                    seed_ready_q <= 1'b0;
                    fsm          <= ST_SEED;
                end
            endcase
        end
    end

    assign bus.out_seed_ready = seed_ready_q;
    assign bus.out_valid      = valid_q;
    assign bus.out_seed_error = error_q;

    // Masks are zero-gated so the raw seed is never visible before RUN.
    always_comb begin
        bus.out_r = '0;
        bus.out_p = '0;
        if (valid_q) begin
            bus.out_r = lfsr[MASK_BITS-1:0];
            bus.out_p = lfsr[2*MASK_BITS-1:MASK_BITS];
        end
    end

endmodule

// File: tb/tb_masked_rand_source.sv
module tb_masked_rand_source;

    localparam int RB = 12;   // 2 muls * 3 pairs * 1 bit, r and p
    localparam int W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    masked_rand_source_if #(.NUM_MULS(2), .NQ(3), .BIT_WIDTH(1)) bus ();
    masked_rand_source_if #(.NUM_MULS(2), .NQ(3), .BIT_WIDTH(1)) bus0 ();

    masked_rand_source #(
        .NUM_SHARES(3), .BIT_WIDTH(1), .NUM_MULS(2), .WARMUP_CYCLES(W)
    ) dut (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus      (bus)
    );

    masked_rand_source #(
        .NUM_SHARES(3), .BIT_WIDTH(1), .NUM_MULS(2), .WARMUP_CYCLES(0)
    ) dut0 (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus      (bus0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_err_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // The LFSR is modelled as a bit stream x[] where x[0..127] is the seed
    // (MS word, MS bit first) and x[n] = x[n-128]^x[n-29]^x[n-27]^x[n-2].
    // After k advances the masks {p,r} bit i equal x[127 + RB*k - i].
    bit          xs[$];
    logic [31:0] m_words[$];
    bit          m_ready, m_valid, m_err, m_zero;
    int          m_delay, m_adv;

    function automatic bit xbit(input int n);
        int k;
        while (xs.size() <= n) begin
            k = xs.size();
            xs.push_back(xs[k-128] ^ xs[k-29] ^ xs[k-27] ^ xs[k-2]);
        end
        return xs[n];
    endfunction

    function automatic logic [RB-1:0] model_masks(input int k);
        logic [RB-1:0] m;
        int t;
        t = 127 + RB * k;
        for (int i = 0; i < RB; i++) m[i] = xbit(t - i);
        return m;
    endfunction

    function automatic void model_load(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        xs.delete();
        for (int j = 0; j < 4; j++)
            for (int b = 31; b >= 0; b--) xs.push_back(w[j][b]);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready = 0; m_valid = 0; m_err = 0; m_delay = 0; m_adv = 0;
            m_words.delete();
        end else begin
            m_err = 0;
            if (m_delay > 0) begin
                m_delay--;
                if (m_delay == 0) begin
                    if (m_zero) begin m_err = 1; m_ready = 1; end
                    else begin m_valid = 1; m_adv = W; end
                end
            end else if (m_valid) begin
                if (bus.in_reseed) begin m_valid = 0; m_ready = 1; end
                else if (bus.in_ready) m_adv++;
            end else if (!m_ready) begin
                m_ready = 1;
            end else if (bus.in_seed_valid) begin
                m_words.push_back(bus.in_seed);
                if (m_words.size() == 4) begin
                    model_load(m_words[0], m_words[1], m_words[2], m_words[3]);
                    m_zero  = (m_words[0] | m_words[1] | m_words[2] | m_words[3]) == 32'h0;
                    m_ready = 0;
                    m_delay = m_zero ? 1 : 1 + W;
                    m_words.delete();
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [RB-1:0] em;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_seed_ready", 64'(bus.out_seed_ready), 64'd0);
            check("rst_valid",      64'(bus.out_valid), 64'd0);
            check("rst_err",        64'(bus.out_seed_error), 64'd0);
            check("rst_masks",      64'({bus.out_p, bus.out_r}), 64'd0);
        end else begin
            em = m_valid ? model_masks(m_adv) : '0;
            check("seed_ready", 64'(bus.out_seed_ready), 64'(m_ready));
            check("valid",      64'(bus.out_valid), 64'(m_valid));
            check("seed_error", 64'(bus.out_seed_error), 64'(m_err));
            check("masks",      64'({bus.out_p, bus.out_r}), 64'(em));
        end
        if (bus.out_seed_error) n_err_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic send_seed(input int n, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input bit gaps);
        logic [31:0] w [4];
        int idx, guard;
        bit v, acc;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        idx = 0; guard = 0;
        while (idx < n && guard < 200) begin
            v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            bus.in_seed_valid = v;
            bus.in_seed       = v ? w[idx] : $urandom();
            bus.in_reseed     = ($urandom_range(0, 3) == 0);
            acc = v && bus.out_seed_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        bus.in_seed_valid = 1'b0;
        bus.in_reseed     = 1'b0;
        if (idx < n) check("seed_handshake_timeout", 64'(idx), 64'(n));
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        if (!bus.out_valid) check("valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic consume(input int target_adv, input int max_cycles);
        int c;
        c = 0;
        while (m_adv < target_adv && c < max_cycles) begin
            bus.in_ready      = ($urandom_range(0, 3) != 0);
            bus.in_seed_valid = bit'($urandom_range(0, 1));
            bus.in_seed       = $urandom();
            tick();
            c++;
        end
        bus.in_ready      = 1'b0;
        bus.in_seed_valid = 1'b0;
        check("advance_target_reached", 64'(m_adv >= target_adv), 64'd1);
    endtask

    initial begin
        int lat;
        logic [RB-1:0] held;
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [RB-1:0] held;
        bus.in_seed = '0; bus.in_seed_valid = 0; bus.in_reseed = 0; bus.in_ready = 0;
        bus0.in_seed = '0; bus0.in_seed_valid = 0; bus0.in_reseed = 0; bus0.in_ready = 0;

        repeat (3) tick();
        check("lit_reset_seed_ready", 64'(bus.out_seed_ready), 64'd0);
        check("lit_reset_masks", 64'({bus.out_p, bus.out_r}), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // zero-warmup instance: seed 0,0,0,ABC shows through directly
        check("lit_w0_ready", 64'(bus0.out_seed_ready), 64'd1);
        for (int j = 0; j < 4; j++) begin
            bus0.in_seed_valid = 1'b1;
            bus0.in_seed       = (j == 3) ? 32'h0000_0ABC : 32'h0;
            tick();
        end
        bus0.in_seed_valid = 1'b0;
        check("lit_w0_check_valid", 64'(bus0.out_valid), 64'd0);
        check("lit_w0_check_ready", 64'(bus0.out_seed_ready), 64'd0);
        tick();
        check("lit_w0_run_valid", 64'(bus0.out_valid), 64'd1);
        check("lit_w0_masks", 64'({bus0.out_p, bus0.out_r}), 64'h0ABC);
        bus0.in_ready = 1'b1;
        tick();
        bus0.in_ready = 1'b0;
        check("lit_w0_adv1_masks", 64'({bus0.out_p, bus0.out_r}), 64'h000);

        // pin the stream model with the same hand-worked values
        model_load(32'h0, 32'h0, 32'h0, 32'h0000_0ABC);
        check("lit_model_adv0", 64'(model_masks(0)), 64'h0ABC);
        check("lit_model_adv1", 64'(model_masks(1)), 64'h000);

        // all-zero seed is rejected with a single error pulse
        send_seed(4, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (4) tick();
        check("lit_zero_seed_err_pulses", 64'(n_err_seen), 64'd1);
        check("lit_zero_seed_valid", 64'(bus.out_valid), 64'd0);

        // random nonzero seed with gaps; first valid after CHECK + warmup
        send_seed(4, $urandom() | 32'h1, $urandom(), $urandom(), $urandom(), 1'b1);
        wait_valid(lat);
        check("lit_latency", 64'(lat), 64'(1 + W));

        // hold: masks stable while in_ready=0
        held = {bus.out_p, bus.out_r};
        repeat (5) begin
            tick();
            check("hold_stable", 64'({bus.out_p, bus.out_r}), 64'(held));
        end

        consume(W + 1000, 4000);

        // reseed with a coincident consume
        bus.in_reseed = 1'b1;
        bus.in_ready  = 1'b1;
        tick();
        bus.in_reseed = 1'b0;
        bus.in_ready  = 1'b0;
        check("lit_reseed_valid", 64'(bus.out_valid), 64'd0);
        check("lit_reseed_ready", 64'(bus.out_seed_ready), 64'd1);
        check("lit_reseed_masks", 64'({bus.out_p, bus.out_r}), 64'd0);

        // partial seed then asynchronous reset
        send_seed(2, $urandom(), $urandom(), 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("lit_async_rst_ready", 64'(bus.out_seed_ready), 64'd0);
        check("lit_async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("lit_async_rst_masks", 64'({bus.out_p, bus.out_r}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        send_seed(4, $urandom() | 32'h8000_0000, $urandom(), $urandom(), $urandom(), 1'b1);
        wait_valid(lat);
        check("lit_restart_latency", 64'(lat), 64'(1 + W));
        consume(W + 300, 1500);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
